chunked_subtractor: RTL
=======================

# chunked_subtractor

Multi-cycle unsigned/two's-complement subtractor: the inverse arithmetic block to the parts-library ripple-carry adder. It computes `in1 - in2 - bi` by rippling a borrow through CHUNK-bit slices, one slice per clock, so only a CHUNK-bit borrow chain is ever on a timing path. It sits in the parts library beside the adder, with a valid/ready handshake on both sides, and is driven by the external C-TB through a Verilator top.

## Interface
- `WIDTH`, default 64: operand and result width in bits.
- `CHUNK`, default 8: bits processed per cycle. `WIDTH` must be an exact multiple of `CHUNK`; the module elaborates with `$error` otherwise. `N = WIDTH/CHUNK`.

Ports:
- `clk`, input, 1: single clock; all flops use the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the operand set is valid.
- `in_ready`, output, 1: the block can accept operands.
- `in1`, input, WIDTH: minuend.
- `in2`, input, WIDTH: subtrahend.
- `bi`, input, 1: borrow in.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer accepts the result.
- `diff`, output, WIDTH: `(in1 - in2 - bi) mod 2^WIDTH`.
- `bo`, output, 1: borrow out; 1 iff `in1 < in2 + bi`, compared as unsigned.
- `ov`, output, 1: signed overflow; 1 iff `in1[MSB] != in2[MSB]` and `diff[MSB] != in1[MSB]`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready = 1`.
  - On an edge where `in_valid && in_ready`: register `in1`, `in2` and `bi`; clear the chunk counter `k` to 0; go to RUN.
- **RUN**
  - Each cycle computes slice k: `{b, d} = a[k] - b_op[k] - borrow`.
  - `borrow` starts at the registered `bi`.
  - Slice k of `diff` is written; `borrow <= b`; `k <= k + 1`.
  - The chunk counter is `$clog2(N)` bits wide, minimum 1 bit.
  - On the edge that processes slice `N-1`: latch `bo` from the final borrow, latch `ov`, go to DONE.
- **DONE**
  - `out_valid = 1`; `diff`, `bo` and `ov` are held stable.
  - On an edge where `out_valid && out_ready`: go to IDLE.
- In every state except IDLE, `in_ready = 0`. While `in_ready = 0`, `in_valid` and the operand inputs are ignored, so changes on them have no effect.
- Operand inputs are sampled only on the accept edge. They may change freely afterwards.
- `diff`, `bo` and `ov` are don't-care outside DONE. The implementation holds the last result.
- `N = 1` (CHUNK == WIDTH) is legal: RUN lasts exactly one cycle.

## Timing
- Reset state (while `rst_n = 0` and after release): IDLE.
  - `in_ready = 1`; `out_valid = 0`.
  - `diff = 0`, `bo = 0`, `ov = 0`; internal operands, borrow and `k` = 0.
- `in_ready` and `out_valid` are decoded directly from state flops, with no combinational path from inputs. There is therefore no input-to-output combinational path.
- Latency:
  - The accept occurs at edge E0.
  - RUN occupies the cycles after edges E0 … E(N-1).
  - `out_valid` rises after edge EN, i.e. N cycles after the accept edge. That is 8 cycles at the default parameters.
- Throughput: at most one operation per N+2 cycles when there is no backpressure.
  - The result is consumed at edge Ec.
  - `in_ready` rises after Ec.
  - The next accept is at Ec+1 at the earliest. There is no same-edge result/accept overlap.
- Backpressure: DONE is held indefinitely while `out_ready = 0`, with all outputs stable.
- Reset asserted mid-operation (RUN or DONE):
  - The operation is aborted immediately and asynchronously.
  - All outputs go to their reset values.
  - No result is ever produced for that operation.
- `out_ready` asserted while not in DONE has no effect.

## Test plan
- **Basic subtract:** `in1=5`, `in2=3`, `bi=0`, accepted at E0.
  - Expect `out_valid` after E8 with `diff=2`, `bo=0`, `ov=0`.
  - `in_ready=0` from E0 until the result is consumed.
- **Unsigned underflow:** `in1=0`, `in2=1`, `bi=0`.
  - Expect `diff=0xFFFF_FFFF_FFFF_FFFF`, `bo=1`, `ov=0`.
- **Signed overflow:** `in1=0x8000_0000_0000_0000`, `in2=1`, `bi=0`.
  - Expect `diff=0x7FFF_FFFF_FFFF_FFFF`, `bo=0`, `ov=1`.
- **Full borrow ripple across all chunks:** `in1=0x00FF`, `in2=0x00FF`, `bi=1`.
  - Expect `diff=0xFFFF_FFFF_FFFF_FFFF`, `bo=1`, `ov=0`.
- **Backpressure:** `out_ready=0` for 5 cycles after `out_valid`, with new `in_valid` pulses and changing operands applied during RUN and DONE.
  - The result stays stable and no accept occurs.
  - `out_ready=1` retires the result; `in_ready=1` on the next cycle.
  - A second operation, `10-4`, yields `diff=6`.
- **Reset mid-operation:** assert `rst_n=0` in the 3rd RUN cycle.
  - `out_valid=0` and `in_ready=1` immediately; `diff=0`.
  - After release, `7-7` with `bi=0` yields `diff=0`, `bo=0` after 8 cycles.
  - No stale result appears at any point.

Source files
------------

// File: rtl/chunked_subtractor_if.sv
// rtl/chunked_subtractor_if.sv - operand/result handshake bundle for chunked_subtractor
interface chunked_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             ov;

    modport master (
        output in_valid, in1, in2, bi, out_ready,
        input  in_ready, out_valid, diff, bo, ov
    );

    modport slave (
        input  in_valid, in1, in2, bi, out_ready,
        output in_ready, out_valid, diff, bo, ov
    );
endinterface

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - multi-cycle subtractor rippling a borrow one CHUNK-bit slice per clock
module chunked_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input logic                clk,
    input logic                rst_n,
    chunked_subtractor_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_subtractor: WIDTH must be an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] diff_q;
    logic             bo_q;
    logic             ov_q;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sub;

    // Handshake flags come straight from the state flops, never from inputs
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.bo        = bo_q;
    assign bus.ov        = ov_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept in IDLE, N slices in RUN, wait for consumer in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select slice k of both operands and form the CHUNK-bit difference plus borrow
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
        sub = {1'b0, a_sl} - {1'b0, b_sl} - {{CHUNK{1'b0}}, borrow_q};
    end

    // Operand capture, slice-by-slice result write and final flag latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            k_q      <= '0;
            diff_q   <= '0;
            bo_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.in1;
                        b_q      <= bus.in2;
                        borrow_q <= bus.bi;
                        k_q      <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < N; i++) begin
                        if (k_q == KW'(i)) begin
                            diff_q[i*CHUNK +: CHUNK] <= sub[CHUNK-1:0];
                        end
                    end
                    borrow_q <= sub[CHUNK];
                    k_q      <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        // The top slice carries the result MSB, so overflow is decided here
                        bo_q <= sub[CHUNK];
                        ov_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                (sub[CHUNK-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
